ecc_rx_monitor_fifo: RTL

- Receive-side stage directly downstream of the ECC bus interface.
- Consumes each beat of corrected data and its error flags, and buffers the beats in a first-word-fall-through FIFO with a valid/ready output.
- Keeps saturating correctable/uncorrectable error counters, captures the first erroneous word, and raises a level interrupt.
- The upstream stage has no backpressure, so this block is where overflow is detected and reported.

---
 rtl/ecc_rx_monitor_fifo.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ecc_rx_monitor_fifo.sv
// ecc_rx_monitor_fifo
//   Receive-side monitor behind the ECC bus interface. Buffers every
//   accepted beat in a first-word-fall-through FIFO (valid/ready out),
//   counts correctable/uncorrectable errors with saturation, captures the
//   first erroneous word, flags dropped beats and raises a level irq.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_data    upstream beat (no backpressure)
//   in_err_det/corr     upstream ECC flags
//   out_valid/ready     FIFO head handshake
//   out_data/out_err    head data and its uncorrectable flag
//   err_thresh          correctable-count irq threshold (0 = off)
//   clr_stats           synchronous clear of statistics
//   corr_count          saturating correctable count
//   uncorr_count        saturating uncorrectable count
//   overflow            sticky drop flag
//   first_err_valid/data first erroneous beat capture
//   irq                 registered level interrupt
module ecc_rx_monitor_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_err_det,
  input  logic             in_err_corr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_err,
  input  logic [CNT_W-1:0] err_thresh,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count,
  output logic             overflow,
  output logic             first_err_valid,
  output logic [31:0]      first_err_data,
  output logic             irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic full, empty, push, pop, drop;
  logic is_corr, is_uncorr;
  logic irq_next;

  // Classification: the corrected flag wins over detected.
  assign is_corr   = in_valid & in_err_corr;
  assign is_uncorr = in_valid & in_err_det & ~in_err_corr;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pop   = ~empty & out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push  = in_valid & (~full | pop);
  assign drop  = in_valid & full & ~pop;

  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem[rd_ptr].data;
  assign out_err   = empty ? 1'b0 : mem[rd_ptr].err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{err: is_uncorr, data: in_data};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Statistics see every classified beat, including dropped ones.
  // Clear takes priority over anything recorded in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_count      <= '0;
      uncorr_count    <= '0;
      overflow        <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_data  <= '0;
    end else if (clr_stats) begin
      corr_count      <= '0;
      uncorr_count    <= '0;
      overflow        <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_data  <= '0;
    end else begin
      if (is_corr && corr_count != '1)
        corr_count <= corr_count + CNT_W'(1);
      if (is_uncorr && uncorr_count != '1)
        uncorr_count <= uncorr_count + CNT_W'(1);
      if (drop)
        overflow <= 1'b1;
      if ((is_corr || is_uncorr) && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_data  <= in_data;
      end
    end
  end

  // irq follows the current statistics one cycle late; a clear therefore
  // drops it on the edge after the statistics themselves go to zero.
  assign irq_next = (uncorr_count != '0) | overflow |
                    ((err_thresh != '0) && (corr_count >= err_thresh));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= irq_next;
  end

endmodule
